// File: rtl/fixed_sqrt_issuer.sv
// Request/result front end for a shared multi-cycle Fixed-point square-root unit.
// One operation in flight; negative radicands and unit timeouts return res_err=1.
module fixed_sqrt_issuer #(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 14,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_rad,
  input  logic [TAG_W-1:0] req_tag,
  output logic             sqrt_strobe,
  output logic [WIDTH-1:0] sqrt_rad,
  input  logic [WIDTH-1:0] sqrt_root,
  input  logic             sqrt_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_root,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2 || FRAC >= WIDTH) begin : g_bad_params
    $error("fixed_sqrt_issuer: TIMEOUT must be >= 2 and FRAC < WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept, capture, timeout_hit;

  // Next-state decode; the first WAIT cycle (wait_cnt==0) ignores a stale sqrt_valid level
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = req_rad[WIDTH-1] ? HOLD : ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (wait_cnt != '0 && sqrt_valid) begin
          capture = 1'b1;
          state_n = HOLD;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE) && !reset;
  assign sqrt_strobe = (state == ISSUE);
  assign res_valid   = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      sqrt_rad <= '0;
      res_root <= '0;
      res_tag  <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        sqrt_rad <= req_rad;
        res_tag  <= req_tag;
        res_root <= '0;
        res_err  <= req_rad[WIDTH-1];
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      // Valid takes precedence; capture and timeout_hit are mutually exclusive
      if (capture) begin
        res_root <= sqrt_root;
        res_err  <= 1'b0;
      end else if (timeout_hit) begin
        res_root <= '0;
        res_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_sqrt_issuer.sv
// Bench for fixed_sqrt_issuer: behavioural sqrt unit with configurable latency,
// scoreboard of expected results keyed by request order.
module tb_fixed_sqrt_issuer;

  localparam int WIDTH   = 32;
  localparam int FRAC    = 14;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_rad = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             sqrt_strobe;
  logic [WIDTH-1:0] sqrt_rad;
  logic [WIDTH-1:0] sqrt_root;
  logic             sqrt_valid;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_root;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [WIDTH-1:0] rad;
    logic [WIDTH-1:0] root;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];

  int               modelLatency = 4;
  bit               modelNever = 1'b0;
  bit               pend = 1'b0;
  int               mcnt = 0;
  logic [WIDTH-1:0] mrad = '0;
  logic             modelValid = 1'b0;
  logic [WIDTH-1:0] modelRoot = 32'hDEAD_BEEF;
  logic             forceValid = 1'b0;
  logic [WIDTH-1:0] staleRoot = 32'h0000_1234;
  int               strobeCount = 0;
  logic [WIDTH-1:0] lastRoot = '0;

  assign sqrt_valid = forceValid | modelValid;
  assign sqrt_root  = forceValid ? staleRoot : modelRoot;

  always #5 clk = ~clk;

  fixed_sqrt_issuer #(
    .WIDTH(WIDTH), .FRAC(FRAC), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rad(req_rad), .req_tag(req_tag),
    .sqrt_strobe(sqrt_strobe), .sqrt_rad(sqrt_rad), .sqrt_root(sqrt_root),
    .sqrt_valid(sqrt_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_root(res_root),
    .res_tag(res_tag), .res_err(res_err)
  );

  // Integer square root of rad * 2^FRAC, i.e. the Q.FRAC root truncated
  function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] rad);
    longint unsigned x, res, b;
    x   = {32'b0, rad} << FRAC;
    res = 0;
    b   = 64'h1 << 62;
    while (b > x) b = b >> 2;
    while (b != 0) begin
      if (x >= res + b) begin
        x   = x - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return res[WIDTH-1:0];
  endfunction

  // Behavioural sqrt unit: one-cycle valid pulse modelLatency cycles after the strobe
  always @(negedge clk) begin
    modelValid = 1'b0;
    modelRoot  = 32'hDEAD_BEEF;
    if (sqrt_strobe) begin
      strobeCount = strobeCount + 1;
      pend = 1'b1;
      mcnt = modelLatency;
      mrad = sqrt_rad;
    end else if (pend && !modelNever) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        modelValid = 1'b1;
        modelRoot  = isqrt(mrad);
        pend       = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance
  task automatic applyStimulus(input logic [WIDTH-1:0] rad, input logic [TAG_W-1:0] tag,
                               input bit expectTimeout);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_rad   = rad;
    req_tag   = tag;
    e.rad  = rad;
    e.tag  = tag;
    e.err  = rad[WIDTH-1] | expectTimeout;
    e.root = e.err ? '0 : isqrt(rad);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_rad   = 32'hA5A5_A5A5;
    checkOutput("strobe_after_accept", 64'(sqrt_strobe), 64'(!rad[WIDTH-1]));
    checkOutput("res_valid_after_accept", 64'(res_valid), 64'(rad[WIDTH-1]));
  endtask

  // Wait for res_valid, stall the consumer holdCycles, then hand off and score
  task automatic collectResult(input int holdCycles, input int expWait);
    int n;
    exp_t e;
    n = 0;
    while (!res_valid && n < TIMEOUT + 40) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checkOutput("res_valid_wait", 64'(res_valid), 64'd1);
      return;
    end
    checkOutput("result_latency", 64'(n), 64'(expWait));
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("hold_valid", 64'(res_valid), 64'd1);
      checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
      checkOutput("hold_root", 64'(res_root), 64'(e.root));
      @(negedge clk);
    end
    res_ready = 1'b1;
    checkOutput("res_root", 64'(res_root), 64'(e.root));
    checkOutput("res_tag", 64'(res_tag), 64'(e.tag));
    checkOutput("res_err", 64'(res_err), 64'(e.err));
    checkOutput("handoff_req_ready", 64'(req_ready), 64'd0);
    if (!e.rad[WIDTH-1]) checkOutput("sqrt_rad_held", 64'(sqrt_rad), 64'(e.rad));
    lastRoot = res_root;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("res_valid_drop", 64'(res_valid), 64'd0);
    checkOutput("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int s0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    checkOutput("reset_ctl", 64'({req_ready, sqrt_strobe, res_valid, res_err, res_tag}), 64'd0);
    checkOutput("reset_data", {sqrt_rad, res_root}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(req_ready), 64'd1);

    // sqrt(3) with latency 4, single strobe
    modelLatency = 4;
    s0 = strobeCount;
    applyStimulus(3 << FRAC, 4'd5, 1'b0);
    collectResult(0, 5);
    checkOutput("single_strobe", 64'(strobeCount - s0), 64'd1);
    checkOutput("root3_range", 64'(lastRoot >= 28377 && lastRoot <= 28379), 64'd1);

    // Stalled consumer
    modelLatency = 3;
    applyStimulus(1947 << FRAC, 4'd2, 1'b0);
    collectResult(5, 4);

    // Assorted radicands including zero and the largest positive value
    modelLatency = 2;
    applyStimulus(32'd0, 4'd1, 1'b0);
    collectResult(0, 3);
    applyStimulus(1 << FRAC, 4'd9, 1'b0);
    collectResult(1, 3);
    applyStimulus(32'h7FFF_FFFF, 4'd15, 1'b0);
    collectResult(0, 3);

    // Negative radicand: no strobe, immediate error result
    s0 = strobeCount;
    applyStimulus(32'hFFFF_FFFF, 4'd7, 1'b0);
    collectResult(0, 0);
    checkOutput("neg_no_strobe", 64'(strobeCount - s0), 64'd0);

    // Unit never answers: abort after TIMEOUT wait cycles
    modelNever = 1'b1;
    applyStimulus(5 << FRAC, 4'd4, 1'b1);
    collectResult(0, TIMEOUT + 1);

    // Stale valid level must be ignored in the first wait cycle, then reset mid-wait
    forceValid = 1'b1;
    applyStimulus(4 << FRAC, 4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("stale_valid_ignored", 64'(res_valid), 64'd0);
    forceValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_wait_valid", 64'(res_valid), 64'd0);
    checkOutput("reset_wait_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_reset_no_result", 64'(res_valid), 64'd0);
    end
    checkOutput("post_reset_idle", 64'({req_ready, sqrt_strobe, res_err}), 64'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

endmodule
